// File: rtl/aes_pkg.sv
// Shared AES encipher definitions: key-length codes, round counts, FSM and
// datapath-update encodings, and the column/row transform functions.
package aes_pkg;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam int AES128_ROUNDS = 10;
  localparam int AES256_ROUNDS = 14;

  // Three-bit encoding leaves spare codes; those fall back to IDLE.
  typedef enum logic [2:0] {
    CTRL_IDLE = 3'd0,
    CTRL_INIT = 3'd1,
    CTRL_SBOX = 3'd2,
    CTRL_MAIN = 3'd3
  } enc_state_e;

  typedef enum logic [2:0] {
    UPD_NONE  = 3'd0,
    UPD_INIT  = 3'd1,
    UPD_SBOX  = 3'd2,
    UPD_MAIN  = 3'd3,
    UPD_FINAL = 3'd4
  } upd_e;

  function automatic logic [7:0] gm2(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] op);
    return gm2(op) ^ op;
  endfunction

  // One column through the {02,03,01,01} circulant; byte 0 is the MSB.
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
            b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] d);
    return {mixw(d[127:96]), mixw(d[95:64]), mixw(d[63:32]), mixw(d[31:0])};
  endfunction

  // Row r of column c lands in column (c - r) mod 4.
  function automatic logic [127:0] shiftrows(input logic [127:0] d);
    logic [31:0] w0, w1, w2, w3;
    w0 = d[127:96];
    w1 = d[95:64];
    w2 = d[63:32];
    w3 = d[31:0];
    return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
            w1[31:24], w2[23:16], w3[15:8], w0[7:0],
            w2[31:24], w3[23:16], w0[15:8], w1[7:0],
            w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] d, input logic [127:0] rk);
    return d ^ rk;
  endfunction

endpackage

// File: rtl/aes_encipher_block_sbox.sv
// aes_sbox: combinational forward S-box applied to all four bytes of a word.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [31:0] sword_i,
  output logic [31:0] new_sword_o
);

  // Entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign new_sword_o = {SBOX[sword_i[31:24]], SBOX[sword_i[23:16]],
                        SBOX[sword_i[15:8]],  SBOX[sword_i[7:0]]};

endmodule

// File: rtl/aes_encipher_block.sv
// aes_encipher_block: iterative AES encipher round engine. The round index
// addresses an external key memory that answers combinationally.
// Optional macro AES_ENC_PARALLEL_SBOX_EN: four S-boxes substitute the whole
// state in one SBOX cycle instead of one word per cycle.
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

`ifdef AES_ENC_PARALLEL_SBOX_EN
  localparam logic PAR_SBOX = 1'b1;
`else
  localparam logic PAR_SBOX = 1'b0;
`endif

  enc_state_e state_q, state_d;
  upd_e       upd;

  // Word 0 is the most significant column of the state.
  logic [0:3][31:0] block_q, sub_block;
  logic [3:0]       round_ctr_q;
  logic [1:0]       sword_ctr_q;
  logic             keylen_q, ready_q;
  logic [3:0]       nr;
  logic             last_round;

  logic round_rst, round_init, round_inc;
  logic sword_rst, sword_inc;
  logic keylen_we, ready_set, ready_clr;

  assign nr         = (keylen_q == AES_256_BIT_KEY) ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);
  assign last_round = !(round_ctr_q < nr);

  assign round     = round_ctr_q;
  assign new_block = block_q;
  assign ready     = ready_q;

`ifdef AES_ENC_PARALLEL_SBOX_EN
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.sword_i(block_q[i]), .new_sword_o(sub_block[i]));
  end
`else
  logic [31:0] sb_in, sb_out;

  assign sb_in = block_q[sword_ctr_q];

  aes_sbox u_sbox (.sword_i(sb_in), .new_sword_o(sb_out));

  // Replace only the word currently selected by the word counter.
  always_comb begin
    sub_block              = block_q;
    sub_block[sword_ctr_q] = sb_out;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CTRL_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_IDLE: if (next) state_d = CTRL_INIT;
      CTRL_INIT: state_d = CTRL_SBOX;
      CTRL_SBOX: if (PAR_SBOX || sword_ctr_q == 2'd3) state_d = CTRL_MAIN;
      CTRL_MAIN: state_d = last_round ? CTRL_IDLE : CTRL_SBOX;
      default:   state_d = CTRL_IDLE;
    endcase
  end

  // FSM outputs: datapath update select and counter/flag controls.
  always_comb begin
    upd        = UPD_NONE;
    round_rst  = 1'b0;
    round_init = 1'b0;
    round_inc  = 1'b0;
    sword_rst  = 1'b0;
    sword_inc  = 1'b0;
    keylen_we  = 1'b0;
    ready_set  = 1'b0;
    ready_clr  = 1'b0;
    case (state_q)
      CTRL_IDLE: begin
        if (next) begin
          round_rst = 1'b1;
          keylen_we = 1'b1;
          ready_clr = 1'b1;
        end
      end
      CTRL_INIT: begin
        upd        = UPD_INIT;
        round_init = 1'b1;
        sword_rst  = 1'b1;
      end
      CTRL_SBOX: begin
        upd       = UPD_SBOX;
        sword_inc = 1'b1;
      end
      CTRL_MAIN: begin
        sword_rst = 1'b1;
        if (last_round) begin
          upd       = UPD_FINAL;
          ready_set = 1'b1;
        end else begin
          upd       = UPD_MAIN;
          round_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Round and S-box word counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_ctr_q <= '0;
      sword_ctr_q <= '0;
    end else begin
      if (round_rst)       round_ctr_q <= 4'd0;
      else if (round_init) round_ctr_q <= 4'd1;
      else if (round_inc)  round_ctr_q <= round_ctr_q + 4'd1;
      if (sword_rst)       sword_ctr_q <= 2'd0;
      else if (sword_inc)  sword_ctr_q <= sword_ctr_q + 2'd1;
    end
  end

  // Key length latched at start; ready drops at start, rises on the final round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keylen_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      if (keylen_we)      keylen_q <= keylen;
      if (ready_clr)      ready_q  <= 1'b0;
      else if (ready_set) ready_q  <= 1'b1;
    end
  end

  // State update: initial key add, S-box pass, main round or final round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_q <= '0;
    end else begin
      case (upd)
        UPD_INIT:  block_q <= addroundkey(block, round_key);
        UPD_SBOX:  block_q <= sub_block;
        UPD_MAIN:  block_q <= addroundkey(mixcolumns(shiftrows(block_q)), round_key);
        UPD_FINAL: block_q <= addroundkey(shiftrows(block_q), round_key);
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: FIPS-197 key memory, byte-level AES model,
// per-cycle compare of ready/round/new_block, and directed literal vectors.
module tb_aes_encipher_block;

`ifdef AES_ENC_PARALLEL_SBOX_EN
  localparam int SB = 1;
`else
  localparam int SB = 4;
`endif
  localparam int L128 = 1 + (SB + 1) * 10;
  localparam int L256 = 1 + (SB + 1) * 14;

  logic         clk, reset_n, next, keylen, ready;
  logic [3:0]   round;
  logic [127:0] round_key, block, new_block;

  aes_encipher_block dut (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen),
    .round(round), .round_key(round_key), .block(block),
    .new_block(new_block), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:14];

  assign round_key = (round < 4'd15) ? rk[round] : '0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r;
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = r;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic load_key(input logic [255:0] key, input bit len);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk = len ? 8 : 4;
    nr = len ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Byte-array AES encryption using the current key memory contents.
  function automatic logic [127:0] aes_model(logic [127:0] pt, int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
      s = t;
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
          s[4*c+3] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Timing/result model: tracks edges since an accepted start.
  bit           m_busy, m_ready, m_known;
  int           m_k, m_nr, m_rnd;
  logic [3:0]   m_round;
  logic [127:0] m_blk, m_exp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_ready = 1; m_known = 1; m_round = 0; m_blk = '0;
    end else if (!m_busy) begin
      if (next === 1'b1) begin
        m_busy = 1; m_k = 0; m_nr = keylen ? 14 : 10;
        m_round = 0; m_ready = 0; m_known = 0;
      end
    end else begin
      m_k++;
      if (m_k == 1) m_exp = aes_model(block, m_nr);
      m_rnd = 1 + (m_k - 1) / (SB + 1);
      m_round = 4'((m_rnd > m_nr) ? m_nr : m_rnd);
      if (m_k == 1 + (SB + 1) * m_nr) begin
        m_busy = 0; m_ready = 1; m_known = 1; m_blk = m_exp;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("ready", 128'(ready), 128'(m_ready));
      chk("round", 128'(round), 128'(m_round));
      if (m_known) chk("new_block", new_block, m_blk);
    end
  end

  task automatic start(input logic [127:0] pt, input bit len);
    block  = pt;
    keylen = len;
    next   = 1'b1;
    @(negedge clk);
    next   = 1'b0;
  endtask

  task automatic run_op(input logic [127:0] pt, input bit len, input bit perturb,
                        output logic [127:0] res, output logic [127:0] mid, output int lat);
    int L;
    L = len ? L256 : L128;
    mid = '0;
    start(pt, len);
    lat = 0;
    while (ready !== 1'b1 && lat < 200) begin
      if (perturb) begin
        next   = (round == 4'd3 || round == 4'd7 || lat == L - 1);
        keylen = (round >= 4'd5) ? ~len : len;
      end
      @(negedge clk);
      lat++;
      if (lat == SB + 2) mid = new_block;
    end
    next   = 1'b0;
    keylen = len;
    if (ready !== 1'b1) chk("ready_timeout", 128'(ready), 128'(1));
    res = new_block;
  endtask

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] res, mid;
    int lat, cnt;
    reset_n = 1'b0; next = 1'b0; keylen = 1'b0; block = '0;
    build_sbox();
    load_key(K128, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_block", new_block, 128'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_en = 1;

    // Pin the model itself.
    chk("model_sbox00", 128'(sb[8'h00]), 128'(8'h63));
    chk("model_sbox53", 128'(sb[8'h53]), 128'(8'hed));
    chk("model_ct128", aes_model(PT1, 10), CT128);

    // AES-128 FIPS vector, with round-1 intermediate.
    run_op(PT1, 1'b0, 1'b0, res, mid, lat);
    chk("ct128", res, CT128);
    chk("lat128", 128'(lat), 128'(L128));
    chk("round1_state", mid, 128'h89d810e8855ace682d1843d8cb128fe4);

    // AES-256 FIPS vector.
    load_key(K256, 1'b1);
    chk("model_ct256", aes_model(PT1, 14), CT256);
    @(negedge clk);
    run_op(PT1, 1'b1, 1'b0, res, mid, lat);
    chk("ct256", res, CT256);
    chk("lat256", 128'(lat), 128'(L256));

    // Busy-time next pulses, keylen toggling, next on the completion edge.
    load_key(K128, 1'b0);
    @(negedge clk);
    run_op(PT1, 1'b0, 1'b1, res, mid, lat);
    chk("ct128_perturb", res, CT128);
    chk("lat128_perturb", 128'(lat), 128'(L128));
    repeat (3) @(negedge clk);
    chk("no_restart", 128'(ready), 128'(1));

    // Reset during round 5, then a clean run.
    start(PT1, 1'b0);
    cnt = 0;
    while (round !== 4'd5 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (round !== 4'd5) chk("reach_round5", 128'(round), 128'(5));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_ready", 128'(ready), 128'(1));
    chk("abort_round", 128'(round), 128'(0));
    chk("abort_block", new_block, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(PT1, 1'b0, 1'b0, res, mid, lat);
    chk("ct128_after_rst", res, CT128);

    // Back-to-back starts in the first IDLE cycle.
    run_op(PT2, 1'b0, 1'b0, res, mid, lat);
    chk("b2b_ct128", res, aes_model(PT2, 10));
    chk("b2b_lat128", 128'(lat), 128'(L128));
    load_key(K256, 1'b1);
    run_op(PT2, 1'b1, 1'b0, res, mid, lat);
    chk("b2b_ct256", res, aes_model(PT2, 14));
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
